reg_wb_ctrl: RTL and testbench



---
 rtl/mips_pkg.sv | 17 +
 rtl/wb_fifo.sv | 86 ++++++++
 rtl/reg_wb_ctrl.sv | 134 +++++++++++++
 tb/tb_reg_wb_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types for the register-file writeback path.
package mips_pkg;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  // 'reg' is a keyword, so the destination field is named rd.
  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic {
    NORMAL = 1'b0,
    DRAIN  = 1'b1
  } wb_state_t;
endpackage

// File: rtl/wb_fifo.sv
// Load writeback FIFO with per-entry kill bit, kill-by-reg and match-by-reg.
module wb_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         push_i,
  input  wb_req_t                      push_req_i,
  input  logic                         pop_i,
  input  logic                         kill_en_i,
  input  logic [REG_W-1:0]             kill_reg_i,
  input  logic [REG_W-1:0]             match_reg_i,
  output wb_req_t                      head_o,
  output logic                         head_killed_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic [$clog2(DEPTH+1)-1:0]   live_o,
  output logic                         match_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  wb_req_t          mem_q [DEPTH];
  logic [DEPTH-1:0] kill_q;
  logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic [DEPTH-1:0] vld;
  logic [PW-1:0]    off;

  // Slot occupancy from its distance past the read pointer.
  always_comb begin
    vld = '0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off    = PW'(i) - rd_ptr_q;
      vld[i] = ({1'b0, off} < count_q);
    end
  end

  // Live (non-killed) entry count and hazard match.
  always_comb begin
    live_o  = '0;
    match_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && !kill_q[i]) begin
        live_o = live_o + CW'(1);
        if (mem_q[i].rd == match_reg_i) match_o = 1'b1;
      end
    end
  end

  assign head_o        = mem_q[rd_ptr_q];
  assign head_killed_o = kill_q[rd_ptr_q];
  assign count_o       = count_q;

  // Payload storage; needs no reset since occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_req_i;
  end

  // Pointers, count and kill bits. A same-cycle push of the killed reg is
  // killed too, since the ALU write is the younger one.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      kill_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en_i && vld[i] && (mem_q[i].rd == kill_reg_i)) kill_q[i] <= 1'b1;
      end
      if (push_i) begin
        kill_q[wr_ptr_q] <= kill_en_i && (push_req_i.rd == kill_reg_i);
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/reg_wb_ctrl.sv
// Register-file write initiator: merges ALU and load results onto one port.
//
// state  | meaning
// NORMAL | ALU accepted; FIFO head drains when the ALU leaves the port idle
// DRAIN  | one cycle: ALU held off, FIFO head forced onto the write port
module reg_wb_ctrl
  import mips_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [REG_W-1:0]           alu_reg,
  input  logic [DATA_W-1:0]          alu_data,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [REG_W-1:0]           ld_reg,
  input  logic [DATA_W-1:0]          ld_data,
  output logic                       regWrite,
  output logic [REG_W-1:0]           wrReg,
  output logic [DATA_W-1:0]          wrData,
  input  logic [REG_W-1:0]           q_reg,
  output logic                       q_hit,
  output logic [$clog2(DEPTH+1)-1:0] pending
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int SW = $clog2(STARVE_MAX+1);
  localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_MAX-1);

  wb_state_t         state_q;
  logic [SW-1:0]     starve_q;
  logic              regWrite_q;
  logic [REG_W-1:0]  wrReg_q;
  logic [DATA_W-1:0] wrData_q;

  wb_req_t       head, ld_req, issue_req_d;
  logic          head_killed, fifo_match;
  logic [CW-1:0] count;
  logic          head_valid, alu_acc, ld_acc, kill_en;
  logic          pop, push, bypass, issue_d;

  assign alu_ready  = (state_q == NORMAL);
  assign ld_ready   = (count < CW'(DEPTH));
  assign alu_acc    = alu_valid && alu_ready;
  assign ld_acc     = ld_valid && ld_ready;
  assign head_valid = (count != '0);
  assign kill_en    = alu_acc && (alu_reg != REG_ZERO);
  assign ld_req.rd   = ld_reg;
  assign ld_req.data = ld_data;

  // Write-port arbitration: forced drain, ALU, FIFO head, then load bypass.
  always_comb begin
    pop         = 1'b0;
    bypass      = 1'b0;
    issue_d     = 1'b0;
    issue_req_d = '0;
    if (state_q == DRAIN && head_valid) begin
      pop         = 1'b1;
      issue_d     = !head_killed;
      issue_req_d = head;
    end else if (kill_en) begin
      issue_d          = 1'b1;
      issue_req_d.rd   = alu_reg;
      issue_req_d.data = alu_data;
    end else if (head_valid) begin
      pop         = 1'b1;
      issue_d     = !head_killed;
      issue_req_d = head;
    end else if (ld_acc && ld_reg != REG_ZERO) begin
      bypass      = 1'b1;
      issue_d     = 1'b1;
      issue_req_d = ld_req;
    end
    push = ld_acc && (ld_reg != REG_ZERO) && !bypass;
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk           (clk),
    .resetN        (resetN),
    .push_i        (push),
    .push_req_i    (ld_req),
    .pop_i         (pop),
    .kill_en_i     (kill_en),
    .kill_reg_i    (alu_reg),
    .match_reg_i   (q_reg),
    .head_o        (head),
    .head_killed_o (head_killed),
    .count_o       (count),
    .live_o        (pending),
    .match_o       (fifo_match)
  );

  // Starvation FSM and the registered write port.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= NORMAL;
      starve_q   <= '0;
      regWrite_q <= 1'b0;
      wrReg_q    <= '0;
      wrData_q   <= '0;
    end else begin
      regWrite_q <= issue_d;
      if (issue_d) begin
        wrReg_q  <= issue_req_d.rd;
        wrData_q <= issue_req_d.data;
      end
      case (state_q)
        NORMAL: begin
          if (!head_valid || pop) begin
            starve_q <= '0;
          end else if (starve_q == STARVE_LAST) begin
            state_q  <= DRAIN;
            starve_q <= '0;
          end else begin
            starve_q <= starve_q + SW'(1);
          end
        end
        DRAIN: begin
          state_q  <= NORMAL;
          starve_q <= '0;
        end
      endcase
    end
  end

  assign regWrite = regWrite_q;
  assign wrReg    = wrReg_q;
  assign wrData   = wrData_q;
  assign q_hit    = (q_reg != REG_ZERO) &&
                    (fifo_match || (regWrite_q && (wrReg_q == q_reg)));
endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Scoreboarded bench for reg_wb_ctrl.
module tb_reg_wb_ctrl;
  import mips_pkg::*;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  logic                       clk = 1'b0;
  logic                       resetN = 1'b0;
  logic                       alu_valid, alu_ready, ld_valid, ld_ready;
  logic [4:0]                 alu_reg, ld_reg, wrReg, q_reg;
  logic [31:0]                alu_data, ld_data, wrData;
  logic                       regWrite, q_hit;
  logic [$clog2(DEPTH+1)-1:0] pending;

  int      n_tests = 0;
  int      n_fail  = 0;
  wb_req_t sb_q[$];

  always #5 clk = ~clk;

  reg_wb_ctrl #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .resetN(resetN),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_reg(ld_reg), .ld_data(ld_data),
    .regWrite(regWrite), .wrReg(wrReg), .wrData(wrData),
    .q_reg(q_reg), .q_hit(q_hit), .pending(pending)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
    ld_valid  = 1'b0; ld_reg  = '0; ld_data  = '0;
  endtask

  task automatic expect_wb(input logic [4:0] r, input logic [31:0] d);
    wb_req_t e;
    e.rd   = r;
    e.data = d;
    sb_q.push_back(e);
  endtask

  // Every write on the register-file port must match the oldest expectation.
  always @(negedge clk) begin
    wb_req_t e;
    if (resetN && regWrite) begin
      chk("wb_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("wb_reg", 32'(wrReg), 32'(e.rd));
        chk("wb_data", wrData, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    q_reg = '0;
    #2;
    chk("rst_regWrite", 32'(regWrite), 32'd0);
    chk("rst_wrReg", 32'(wrReg), 32'd0);
    chk("rst_wrData", wrData, 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_alu_ready", 32'(alu_ready), 32'd1);
    chk("rst_ld_ready", 32'(ld_ready), 32'd1);
    @(negedge clk);
    resetN = 1'b1;
    step();

    // load bypass
    ld_valid = 1'b1; ld_reg = 5'd5; ld_data = 32'hDEADBEEF;
    expect_wb(5'd5, 32'hDEADBEEF);
    step();
    idle();
    q_reg = 5'd5;
    #1;
    chk("byp_regWrite", 32'(regWrite), 32'd1);
    chk("byp_pending", 32'(pending), 32'd0);
    chk("byp_qhit", 32'(q_hit), 32'd1);
    step();
    step();

    // ALU priority, load queued
    alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 32'h11;
    ld_valid  = 1'b1; ld_reg  = 5'd7; ld_data  = 32'h22;
    expect_wb(5'd3, 32'h11);
    expect_wb(5'd7, 32'h22);
    step();
    idle();
    q_reg = 5'd7;
    #1;
    chk("pri_pending1", 32'(pending), 32'd1);
    chk("pri_qhit_fifo", 32'(q_hit), 32'd1);
    step();
    chk("pri_pending0", 32'(pending), 32'd0);
    chk("pri_qhit_out", 32'(q_hit), 32'd1);
    step();
    chk("pri_qhit_clear", 32'(q_hit), 32'd0);
    step();

    // full FIFO under a continuous ALU stream, then forced drain
    for (int c = 0; c <= 10; c++) begin
      alu_valid = (c < 10);
      alu_reg   = 5'(1 + c);
      alu_data  = 32'h1000 + 32'(c);
      ld_valid  = (c < 4);
      ld_reg    = 5'(20 + c);
      ld_data   = 32'h100 + 32'(c);
      #1;
      chk("stv_alu_ready", 32'(alu_ready), (c == 9) ? 32'd0 : 32'd1);
      chk("stv_ld_ready", 32'(ld_ready), (c < 4 || c >= 10) ? 32'd1 : 32'd0);
      if (c <= 8) expect_wb(5'(1 + c), 32'h1000 + 32'(c));
      if (c == 9) begin
        expect_wb(5'd20, 32'h100);
        chk("stv_pending_full", 32'(pending), 32'd4);
      end
      if (c == 10) begin
        expect_wb(5'd21, 32'h101);
        chk("stv_pending_after", 32'(pending), 32'd3);
      end
      step();
    end
    idle();
    expect_wb(5'd22, 32'h102);
    expect_wb(5'd23, 32'h103);
    repeat (3) step();
    chk("stv_pending_empty", 32'(pending), 32'd0);

    // WAW kill
    alu_valid = 1'b1; alu_reg = 5'd1; alu_data = 32'h1;
    ld_valid  = 1'b1; ld_reg  = 5'd9; ld_data  = 32'hAA;
    expect_wb(5'd1, 32'h1);
    step();
    ld_valid = 1'b0;
    alu_reg  = 5'd9; alu_data = 32'hBB;
    q_reg    = 5'd9;
    #1;
    chk("waw_qhit_q", 32'(q_hit), 32'd1);
    chk("waw_pending1", 32'(pending), 32'd1);
    expect_wb(5'd9, 32'hBB);
    step();
    idle();
    #1;
    chk("waw_pending0", 32'(pending), 32'd0);
    chk("waw_qhit_out", 32'(q_hit), 32'd1);
    step();
    chk("waw_no_write", 32'(regWrite), 32'd0);
    chk("waw_qhit_drop", 32'(q_hit), 32'd0);
    step();

    // register zero
    alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'h55;
    ld_valid  = 1'b1; ld_reg  = 5'd0; ld_data  = 32'h66;
    q_reg     = 5'd0;
    #1;
    chk("zero_alu_ready", 32'(alu_ready), 32'd1);
    chk("zero_ld_ready", 32'(ld_ready), 32'd1);
    step();
    idle();
    chk("zero_regWrite", 32'(regWrite), 32'd0);
    chk("zero_pending", 32'(pending), 32'd0);
    chk("zero_qhit", 32'(q_hit), 32'd0);
    step();
    chk("zero_regWrite2", 32'(regWrite), 32'd0);

    // asynchronous reset with three loads queued
    for (int c = 0; c < 3; c++) begin
      alu_valid = 1'b1; alu_reg = 5'(1 + c); alu_data = 32'h2000 + 32'(c);
      ld_valid  = 1'b1; ld_reg  = 5'(20 + c); ld_data  = 32'h300 + 32'(c);
      expect_wb(5'(1 + c), 32'h2000 + 32'(c));
      step();
    end
    idle();
    #1;
    chk("mrst_pending_pre", 32'(pending), 32'd3);
    @(negedge clk);
    #1;
    resetN = 1'b0;
    #1;
    chk("mrst_regWrite", 32'(regWrite), 32'd0);
    chk("mrst_pending", 32'(pending), 32'd0);
    chk("mrst_ld_ready", 32'(ld_ready), 32'd1);
    chk("mrst_alu_ready", 32'(alu_ready), 32'd1);
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    repeat (6) step();
    chk("mrst_pending_post", 32'(pending), 32'd0);

    repeat (2) step();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
